// File: rtl/alu_pkg.sv
// Opcodes shared by the ALU and its issue sequencer, plus the sequencer state encoding.
package alu_pkg;
  localparam int ALU_OP_W       = 4;
  localparam int MAX_SHIFT_STEP = 7;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_INC = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_DEC = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_NOT = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

  function automatic logic is_shift(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_SRL) || (op == ALU_SLL) || (op == ALU_SRA);
  endfunction

  function automatic logic is_illegal(input logic [ALU_OP_W-1:0] op);
    return op > ALU_SRA;
  endfunction
endpackage

// File: rtl/alu.sv
// MIPS datapath ALU: combinational, shifts limited to b[2:0]; zero_flag is HIGH for a non-zero result.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [ALU_OP_W-1:0] opcode,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [WIDTH-1:0]    data_out,
  output logic                zero_flag
);
  logic [2:0] sh;
  assign sh = b[2:0];

  always_comb begin
    data_out = '0;
    unique case (opcode)
      ALU_ADD: data_out = a + b;
      ALU_SUB: data_out = a - b;
      ALU_INC: data_out = a + WIDTH'(1);
      ALU_DEC: data_out = a - WIDTH'(1);
      ALU_AND: data_out = a & b;
      ALU_OR:  data_out = a | b;
      ALU_NOT: data_out = ~a;
      ALU_XOR: data_out = a ^ b;
      ALU_SRL: data_out = a >> sh;
      ALU_SLL: data_out = a << sh;
      ALU_SRA: data_out = $unsigned($signed(a) >>> sh);
      default: data_out = '0;
    endcase
  end

  assign zero_flag = |data_out;
endmodule

// File: rtl/alu_shift_step.sv
// Splits the remaining shift amount into one ALU-sized pass.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int SHAMT_W = 5
) (
  input  logic [SHAMT_W-1:0] rem_i,
  output logic [2:0]         step_o,
  output logic               last_o
);
  assign last_o = rem_i <= SHAMT_W'(MAX_SHIFT_STEP);
  assign step_o = last_o ? rem_i[2:0] : 3'(MAX_SHIFT_STEP);
endmodule

// File: rtl/alu_op_sequencer.sv
// Issue-side ALU controller: one op per handshake, long shifts run as repeated <=7 passes.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ALU_OP_W-1:0] req_op,
  input  logic [WIDTH-1:0]    req_a,
  input  logic [WIDTH-1:0]    req_b,
  input  logic [SHAMT_W-1:0]  req_shamt,
  output logic [ALU_OP_W-1:0] alu_opcode,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic                alu_zero_flag,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_result,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic                busy
);
  seq_state_e          state_q, state_d;
  logic [ALU_OP_W-1:0] op_q, op_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [SHAMT_W-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]    res_q, res_d;
  logic                zero_q, zero_d;
  logic                err_q, err_d;
  logic [2:0]          step;
  logic                last;

  alu_shift_step #(.SHAMT_W(SHAMT_W)) u_step (
    .rem_i  (rem_q),
    .step_o (step),
    .last_o (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // acc_q holds operand a and, during SHIFT, the running partial result.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    b_d     = b_q;
    rem_d   = rem_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (req_valid) begin
        op_d  = req_op;
        acc_d = req_a;
        b_d   = req_b;
        rem_d = req_shamt;
        if (is_illegal(req_op)) begin
          res_d   = '0;
          zero_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (is_shift(req_op)) begin
          state_d = S_SHIFT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        zero_d  = ~alu_zero_flag;
        err_d   = 1'b0;
        state_d = S_DONE;
      end
      S_SHIFT: begin
        acc_d = alu_result;
        rem_d = rem_q - SHAMT_W'(step);
        if (last) begin
          res_d   = alu_result;
          zero_d  = ~alu_zero_flag;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs read zero for the whole reset cycle, whatever state was left behind.
  always_comb begin
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    if (!rst && state_q == S_EXEC) begin
      alu_opcode = op_q;
      alu_a      = acc_q;
      alu_b      = b_q;
    end else if (!rst && state_q == S_SHIFT) begin
      alu_opcode = op_q;
      alu_a      = acc_q;
      alu_b      = WIDTH'(step);
    end
    req_ready  = !rst && state_q == S_IDLE;
    rsp_valid  = !rst && state_q == S_DONE;
    busy       = !rst && state_q != S_IDLE;
    rsp_result = rst ? '0 : res_q;
    rsp_zero   = !rst && zero_q;
    rsp_err    = !rst && err_q;
  end
endmodule
